// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the dual-port RAM arbiter.
package ram_pkg;

    localparam int DEPTH = 128;   // number of RAM locations
    localparam int AW    = 8;     // address width
    localparam int DW    = 8;     // data width

    // INIT clears the RAM after reset; ARB serves the two requesters.
    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// port named by Ptr (0 = A, 1 = B). At most one grant is ever high.
module rr_arb2 (
    input  logic ReqA,
    input  logic ReqB,
    input  logic Ptr,
    output logic GntA,
    output logic GntB
);

    // Combinational grant decision from the two requests and the pointer.
    always_comb begin
        GntA = ReqA & (~ReqB | ~Ptr);
        GntB = ReqB & (~ReqA |  Ptr);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two request ports onto one synchronous single-port RAM.
// After reset the RAM is cleared one word per cycle (INIT), then each cycle
// at most one request is granted combinationally and driven to the RAM.
// Read data, read-valid and error flags are returned one cycle after grant.
//
// Handshake: a port raises Req with We/Addr/Din stable and holds it; the
// cycle in which its Gnt is high (sampled at the rising edge) is the
// acceptance, and the port may change or drop Req from the next cycle on.
module ram_arbiter #(
    parameter int DEPTH = ram_pkg::DEPTH,
    parameter int AW    = ram_pkg::AW,
    parameter int DW    = ram_pkg::DW
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          ReqA,
    input  logic          ReqB,
    input  logic          WeA,
    input  logic          WeB,
    input  logic [AW-1:0] AddrA,
    input  logic [AW-1:0] AddrB,
    input  logic [DW-1:0] DinA,
    input  logic [DW-1:0] DinB,
    output logic          GntA,
    output logic          GntB,
    output logic          RdValidA,
    output logic          RdValidB,
    output logic [DW-1:0] RdDataA,
    output logic [DW-1:0] RdDataB,
    output logic          ErrA,
    output logic          ErrB,
    output logic          Ready,
    output logic [AW-1:0] RamAddr,
    output logic [DW-1:0] RamDin,
    output logic          RamEN,
    output logic          RamWE,
    input  logic [DW-1:0] RamDOut
);

    import ram_pkg::*;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ptr_q, ptr_d;        // 0 = A wins a tie, 1 = B wins a tie
    logic          ready_q, ready_d;
    logic          rv_a_q, rv_a_d;
    logic          rv_b_q, rv_b_d;
    logic          err_a_q, err_a_d;
    logic          err_b_q, err_b_d;
    logic          hit_a_q, hit_a_d;    // pending read was served by the RAM
    logic          hit_b_q, hit_b_d;

    logic          arb_req_a, arb_req_b;
    logic          gnt_a, gnt_b;
    logic          in_range_a, in_range_b;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;

    // Requests are only visible to the arbiter once initialisation is done;
    // during INIT they stay asserted at the ports and are served afterwards.
    always_comb begin
        arb_req_a  = ReqA & (state_q == ARB);
        arb_req_b  = ReqB & (state_q == ARB);
        in_range_a = {1'b0, AddrA} < DEPTH_W;
        in_range_b = {1'b0, AddrB} < DEPTH_W;
    end

    rr_arb2 u_rr_arb2 (
        .ReqA (arb_req_a),
        .ReqB (arb_req_b),
        .Ptr  (ptr_q),
        .GntA (gnt_a),
        .GntB (gnt_b)
    );

    // Next-state, RAM drive and next-cycle response flags.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        ready_d  = ready_q;
        rv_a_d   = 1'b0;
        rv_b_d   = 1'b0;
        err_a_d  = 1'b0;
        err_b_d  = 1'b0;
        hit_a_d  = 1'b0;
        hit_b_d  = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state_q)
            INIT: begin
                // Reset holds the FSM in INIT; keep the RAM idle until release.
                ram_en   = RST_N;
                ram_we   = RST_N;
                ram_addr = cnt_q;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ADR) begin
                    state_d = ARB;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ARB: begin
                if (gnt_a) begin
                    ram_en   = in_range_a;
                    ram_we   = WeA & in_range_a;
                    ram_addr = AddrA;
                    ram_din  = DinA;
                    rv_a_d   = ~WeA;
                    err_a_d  = ~in_range_a;
                    hit_a_d  = ~WeA & in_range_a;
                    ptr_d    = 1'b1;
                end else if (gnt_b) begin
                    ram_en   = in_range_b;
                    ram_we   = WeB & in_range_b;
                    ram_addr = AddrB;
                    ram_din  = DinB;
                    rv_b_d   = ~WeB;
                    err_b_d  = ~in_range_b;
                    hit_b_d  = ~WeB & in_range_b;
                    ptr_d    = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // FSM and registered outputs; reset aborts INIT and drops pending pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            ready_q <= 1'b0;
            rv_a_q  <= 1'b0;
            rv_b_q  <= 1'b0;
            err_a_q <= 1'b0;
            err_b_q <= 1'b0;
            hit_a_q <= 1'b0;
            hit_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            rv_a_q  <= rv_a_d;
            rv_b_q  <= rv_b_d;
            err_a_q <= err_a_d;
            err_b_q <= err_b_d;
            hit_a_q <= hit_a_d;
            hit_b_q <= hit_b_d;
        end
    end

    // Output mapping; out-of-range reads and idle ports return zero data.
    always_comb begin
        GntA     = gnt_a;
        GntB     = gnt_b;
        Ready    = ready_q;
        RdValidA = rv_a_q;
        RdValidB = rv_b_q;
        ErrA     = err_a_q;
        ErrB     = err_b_q;
        RdDataA  = hit_a_q ? RamDOut : '0;
        RdDataB  = hit_b_q ? RamDOut : '0;
        RamEN    = ram_en;
        RamWE    = ram_we;
        RamAddr  = ram_addr;
        RamDin   = ram_din;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, cycle-level reference model, vector
// table, hand sequences for reset corner cases, and randomized traffic.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int DEPTH = 128;
    localparam int AW    = 8;
    localparam int DW    = 8;

    // ---------------- clock / reset / DUT ----------------
    logic          CLK = 1'b0;
    logic          RST_N;
    logic          ReqA, ReqB, WeA, WeB;
    logic [AW-1:0] AddrA, AddrB;
    logic [DW-1:0] DinA, DinB;
    logic          GntA, GntB, RdValidA, RdValidB, ErrA, ErrB, Ready;
    logic [DW-1:0] RdDataA, RdDataB;
    logic [AW-1:0] RamAddr;
    logic [DW-1:0] RamDin, RamDOut;
    logic          RamEN, RamWE;

    always #5 CLK = ~CLK;

    ram_arbiter dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ReqA     (ReqA),
        .ReqB     (ReqB),
        .WeA      (WeA),
        .WeB      (WeB),
        .AddrA    (AddrA),
        .AddrB    (AddrB),
        .DinA     (DinA),
        .DinB     (DinB),
        .GntA     (GntA),
        .GntB     (GntB),
        .RdValidA (RdValidA),
        .RdValidB (RdValidB),
        .RdDataA  (RdDataA),
        .RdDataB  (RdDataB),
        .ErrA     (ErrA),
        .ErrB     (ErrB),
        .Ready    (Ready),
        .RamAddr  (RamAddr),
        .RamDin   (RamDin),
        .RamEN    (RamEN),
        .RamWE    (RamWE),
        .RamDOut  (RamDOut)
    );

    // ---------------- synchronous RAM model ----------------
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_dout = '0;
    logic          scramble = 1'b1;

    always @(posedge CLK) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= DW'((i * 37 + 91) | 1);
        end else if (RamEN) begin
            if (RamWE) ram_mem[RamAddr[6:0]] <= RamDin;
            else       ram_dout <= ram_mem[RamAddr[6:0]];
        end
    end
    assign RamDOut = ram_dout;

    // ---------------- scoreboard / counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_ready;
    int            m_init;
    bit            m_prio_b;          // a tie goes to B when set
    logic [DW-1:0] m_mem [DEPTH];
    bit            e_rv_a, e_rv_b, e_err_a, e_err_b;
    logic [DW:0]   exp_q[$];          // {port is B, expected read data}

    task automatic model_reset();
        m_ready  = 0;
        m_init   = 0;
        m_prio_b = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        e_rv_a = 0; e_rv_b = 0; e_err_a = 0; e_err_b = 0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge,
    // advance the model. Entered and left 1 ns after a rising edge.
    task automatic step(input bit ra, input bit wa, input logic [7:0] aa, input logic [7:0] da,
                        input bit rb, input bit wb, input logic [7:0] ab, input logic [7:0] db,
                        output int act_win, output bit act_en, output bit act_rdy,
                        output int exp_win);
        int            win;
        logic [DW:0]   e;
        logic [DW-1:0] exp_a, exp_b;
        bit            we, inr;
        logic [7:0]    addr, din;
        ReqA = ra; WeA = wa; AddrA = aa; DinA = da;
        ReqB = rb; WeB = wb; AddrB = ab; DinB = db;
        @(negedge CLK);
        act_win = GntA ? (GntB ? 3 : 1) : (GntB ? 2 : 0);
        act_en  = RamEN;
        act_rdy = Ready;
        // responses to the previous cycle
        exp_a = '0;
        exp_b = '0;
        if ((e_rv_a || e_rv_b) && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[DW]) exp_b = e[DW-1:0];
            else       exp_a = e[DW-1:0];
        end
        check("ready", Ready, m_ready);
        check("rd_valid_a", RdValidA, e_rv_a);
        check("rd_valid_b", RdValidB, e_rv_b);
        check("err_a", ErrA, e_err_a);
        check("err_b", ErrB, e_err_b);
        check("rd_data_a", RdDataA, exp_a);
        check("rd_data_b", RdDataB, exp_b);
        e_rv_a = 0; e_rv_b = 0; e_err_a = 0; e_err_b = 0;
        win = 0;
        if (!m_ready) begin
            check("init_gnt", act_win, 0);
            check("init_ram_en", RamEN, 1);
            check("init_ram_we", RamWE, 1);
            check("init_ram_addr", RamAddr, m_init);
            check("init_ram_din", RamDin, 0);
            m_init++;
            if (m_init == DEPTH) m_ready = 1;
        end else begin
            if (ra && rb) win = m_prio_b ? 2 : 1;
            else if (ra)  win = 1;
            else if (rb)  win = 2;
            check("gnt", act_win, win);
            if (win == 0) begin
                check("idle_ram_en", RamEN, 0);
                check("idle_ram_we", RamWE, 0);
            end else begin
                we   = (win == 1) ? wa : wb;
                addr = (win == 1) ? aa : ab;
                din  = (win == 1) ? da : db;
                inr  = addr < DEPTH;
                check("ram_en", RamEN, inr);
                check("ram_we", RamWE, inr && we);
                if (inr) check("ram_addr", RamAddr, addr);
                if (inr && we) check("ram_din", RamDin, din);
                if (!we) exp_q.push_back({(win == 2) ? 1'b1 : 1'b0, inr ? m_mem[addr[6:0]] : 8'h00});
                if (win == 1) begin e_rv_a = !we; e_err_a = !inr; end
                else          begin e_rv_b = !we; e_err_b = !inr; end
                if (inr && we) m_mem[addr[6:0]] = din;
                m_prio_b = (win == 1);
            end
        end
        exp_win = win;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        int w, ew; bit en, rdy;
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, w, en, rdy, ew);
    endtask

    // Asynchronous reset mid-cycle: everything must clear at once.
    task automatic apply_reset(input int hold);
        ReqA = 0; ReqB = 0; WeA = 0; WeB = 0;
        AddrA = '0; AddrB = '0; DinA = '0; DinB = '0;
        RST_N = 1'b0;
        #1;
        check("rst_ready", Ready, 0);
        check("rst_gnt", {GntA, GntB}, 0);
        check("rst_rd_valid", {RdValidA, RdValidB}, 0);
        check("rst_err", {ErrA, ErrB}, 0);
        check("rst_ram_en", RamEN, 0);
        check("rst_ram_we", RamWE, 0);
        check("rst_rd_data", {RdDataA, RdDataB}, 0);
        model_reset();
        repeat (hold) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    // Steps until the DUT reports Ready (bounded); n = INIT cycles seen.
    task automatic run_init(input bit ra, input bit rb, output int n, output int first_win);
        int w, ew; bit en, rdy;
        n = 0;
        first_win = 0;
        for (int i = 0; i < 300; i++) begin
            step(ra, 0, 8'h00, 8'h00, rb, 0, 8'h01, 8'h00, w, en, rdy, ew);
            if (rdy) begin
                first_win = w;
                break;
            end
            n++;
        end
    endtask

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 8'($urandom_range(128, 255));
        return 8'($urandom_range(0, 15));
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit         ra;
        bit         wa;
        logic [7:0] aa;
        logic [7:0] da;
        bit         rb;
        bit         wb;
        logic [7:0] ab;
        logic [7:0] db;
        int         ewin;
        bit         een;
    } vec_t;

    vec_t vt [13];

    // ---------------- main sequence ----------------
    initial begin
        int         n, w, ew, fw;
        bit         en, rdy;
        int         order [4];
        bit         pa, pb, wa_r, wb_r;
        logic [7:0] aa_r, ab_r, da_r, db_r;

        vt[0]  = '{1, 1, 8'h05, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 1};
        vt[1]  = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00, 2, 1};
        vt[2]  = '{1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1, 1};
        vt[3]  = '{1, 0, 8'h11, 8'h00, 1, 0, 8'h20, 8'h00, 2, 1};
        vt[4]  = '{1, 0, 8'h11, 8'h00, 1, 0, 8'h21, 8'h00, 1, 1};
        vt[5]  = '{1, 0, 8'h12, 8'h00, 1, 0, 8'h21, 8'h00, 2, 1};
        vt[6]  = '{1, 0, 8'h80, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0};
        vt[7]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0};
        vt[8]  = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h7F, 8'h3C, 2, 1};
        vt[9]  = '{1, 0, 8'h7F, 8'h00, 1, 0, 8'hFF, 8'h00, 1, 1};
        vt[10] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 2, 0};
        vt[11] = '{1, 1, 8'h90, 8'h5A, 0, 0, 8'h00, 8'h00, 1, 0};
        vt[12] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0};

        RST_N = 1'b0;
        ReqA = 0; ReqB = 0; WeA = 0; WeB = 0;
        AddrA = '0; AddrB = '0; DinA = '0; DinB = '0;
        model_reset();
        @(posedge CLK);
        #1;
        scramble = 1'b0;
        apply_reset(2);

        // Power-up clear with port A already requesting, then read every word.
        run_init(1, 0, n, fw);
        check("init_cycles", n, DEPTH);
        check("first_ready_gnt", fw, 1);
        for (int i = 0; i < DEPTH; i++)
            step(1, 0, 8'(i), 8'h00, 0, 0, 8'h00, 8'h00, w, en, rdy, ew);
        idle();

        // Directed vectors: write/read-back, round robin, out-of-range.
        for (int i = 0; i < 13; i++) begin
            step(vt[i].ra, vt[i].wa, vt[i].aa, vt[i].da,
                 vt[i].rb, vt[i].wb, vt[i].ab, vt[i].db, w, en, rdy, ew);
            check($sformatf("vec%0d_gnt", i), w, vt[i].ewin);
            check($sformatf("vec%0d_ram_en", i), en, vt[i].een);
        end

        // Reset in the cycle after a read grant drops the read pulse.
        step(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, w, en, rdy, ew);
        check("pre_rst_gnt", w, 1);
        apply_reset(1);

        // Reset while INIT is at address 0x40, then a full restart.
        for (int i = 0; i < 'h40; i++) idle();
        apply_reset(1);
        run_init(1, 1, n, fw);
        check("reinit_cycles", n, DEPTH);
        order[0] = fw;
        for (int i = 1; i < 4; i++) begin
            step(1, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, w, en, rdy, ew);
            order[i] = w;
        end
        check("rr_order0", order[0], 1);
        check("rr_order1", order[1], 2);
        check("rr_order2", order[2], 1);
        check("rr_order3", order[3], 2);
        idle();

        // Random traffic: requests held until the model says they were granted.
        pa = 0; pb = 0;
        wa_r = 0; wb_r = 0; aa_r = '0; ab_r = '0; da_r = '0; db_r = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && $urandom_range(0, 9) < 6) begin
                pa = 1; wa_r = 1'($urandom_range(0, 1)); aa_r = rand_addr(); da_r = 8'($urandom_range(0, 255));
            end
            if (!pb && $urandom_range(0, 9) < 6) begin
                pb = 1; wb_r = 1'($urandom_range(0, 1)); ab_r = rand_addr(); db_r = 8'($urandom_range(0, 255));
            end
            step(pa, wa_r, aa_r, da_r, pb, wb_r, ab_r, db_r, w, en, rdy, ew);
            if (ew == 1) pa = 0;
            if (ew == 2) pb = 0;
        end
        idle();
        idle();
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
